// File: rtl/sdram_port_arbiter.sv
// Three-client front end for the single-port SDRAM controller:
// loader writes, CPU and graphics ROM reads, each read port cached by one word.
module sdram_port_arbiter #(
    parameter int RD_WAIT = 16,
    parameter int WR_WAIT = 12
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        dl_we,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic        dl_overflow,

    input  logic        cpu_req,
    input  logic [24:0] cpu_addr,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,

    input  logic        gfx_req,
    input  logic [24:0] gfx_addr,
    output logic [15:0] gfx_dout,
    output logic        gfx_ack,

    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_wtbt,
    output logic        sd_we,
    output logic        sd_rd,
    input  logic [15:0] sd_dout
);

    localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW   = $clog2(MAXW) + 1;

    typedef enum logic [3:0] {
        IDLE,
        HIT_CPU,
        HIT_GFX,
        RISSUE,
        RWAIT,
        RDONE,
        WISSUE,
        WWAIT,
        WDONE
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic        sel_gfx;
    logic [23:0] rd_tag;

    logic        pend;
    logic [24:0] pend_addr;
    logic [7:0]  pend_data;
    logic        dl_seen;

    logic        cpu_vld;
    logic [23:0] cpu_tag;
    logic        gfx_vld;
    logic [23:0] gfx_tag;

    logic        dl_acc;
    logic        cpu_hit;
    logic        gfx_hit;
    logic        unused_addr_lsb;

    // A write arriving on the very cycle the pending one retires still fits.
    assign dl_acc  = dl_we && (!pend || state == WDONE);
    assign cpu_hit = cpu_vld && (cpu_addr[24:1] == cpu_tag);
    assign gfx_hit = gfx_vld && (gfx_addr[24:1] == gfx_tag);
    assign unused_addr_lsb = cpu_addr[0] ^ gfx_addr[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel_gfx     <= 1'b0;
            rd_tag      <= '0;
            pend        <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            dl_seen     <= 1'b0;
            dl_overflow <= 1'b0;
            cpu_vld     <= 1'b0;
            cpu_tag     <= '0;
            gfx_vld     <= 1'b0;
            gfx_tag     <= '0;
            cpu_dout    <= '0;
            cpu_ack     <= 1'b0;
            gfx_dout    <= '0;
            gfx_ack     <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_wtbt     <= '0;
            sd_we       <= 1'b0;
            sd_rd       <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            gfx_ack <= 1'b0;
            sd_wtbt <= 2'b00;

            if (dl_acc) begin
                pend      <= 1'b1;
                pend_addr <= dl_addr;
                pend_data <= dl_data;
            end else if (state == WDONE) begin
                pend <= 1'b0;
            end

            if (dl_we && !dl_acc)
                dl_overflow <= 1'b1;

            // Tracks loader activity since the current read was chosen.
            if (state == IDLE)
                dl_seen <= dl_acc;
            else if (dl_acc)
                dl_seen <= 1'b1;

            unique case (state)
                IDLE: begin
                    if (pend) begin
                        state <= WISSUE;
                    end else if (cpu_req && cpu_hit) begin
                        state <= HIT_CPU;
                    end else if (cpu_req) begin
                        sel_gfx <= 1'b0;
                        state   <= RISSUE;
                    end else if (gfx_req && gfx_hit) begin
                        state <= HIT_GFX;
                    end else if (gfx_req) begin
                        sel_gfx <= 1'b1;
                        state   <= RISSUE;
                    end
                end
                HIT_CPU: begin
                    cpu_ack <= 1'b1;
                    state   <= IDLE;
                end
                HIT_GFX: begin
                    gfx_ack <= 1'b1;
                    state   <= IDLE;
                end
                RISSUE: begin
                    if (sel_gfx) begin
                        rd_tag  <= gfx_addr[24:1];
                        sd_addr <= {gfx_addr[24:1], 1'b0};
                    end else begin
                        rd_tag  <= cpu_addr[24:1];
                        sd_addr <= {cpu_addr[24:1], 1'b0};
                    end
                    sd_rd <= 1'b1;
                    cnt   <= CW'(RD_WAIT - 1);
                    state <= RWAIT;
                end
                RWAIT: begin
                    if (cnt == '0)
                        state <= RDONE;
                    else
                        cnt <= cnt - CW'(1);
                end
                RDONE: begin
                    sd_rd <= 1'b0;
                    if (sel_gfx) begin
                        gfx_dout <= sd_dout;
                        gfx_ack  <= 1'b1;
                        gfx_tag  <= rd_tag;
                        gfx_vld  <= !(dl_seen || dl_acc);
                    end else begin
                        cpu_dout <= sd_dout;
                        cpu_ack  <= 1'b1;
                        cpu_tag  <= rd_tag;
                        cpu_vld  <= !(dl_seen || dl_acc);
                    end
                    state <= IDLE;
                end
                WISSUE: begin
                    sd_addr <= pend_addr;
                    sd_din  <= {pend_data, pend_data};
                    sd_we   <= 1'b1;
                    cnt     <= CW'(WR_WAIT - 1);
                    state   <= WWAIT;
                end
                WWAIT: begin
                    if (cnt == '0) begin
                        sd_we <= 1'b0;
                        state <= WDONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WDONE: begin
                    sd_we <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // New ROM contents make any cached word stale.
            if (dl_acc) begin
                cpu_vld <= 1'b0;
                gfx_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction-timeline model plus directed
// scenarios against a byte-array SDRAM stand-in.
module tb_sdram_port_arbiter;

    localparam int RD_WAIT = 16;
    localparam int WR_WAIT = 12;

    logic        clk;
    logic        reset;
    logic        dl_we;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_overflow;
    logic        cpu_req;
    logic [24:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic        gfx_req;
    logic [24:0] gfx_addr;
    logic [15:0] gfx_dout;
    logic        gfx_ack;
    logic [24:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_wtbt;
    logic        sd_we;
    logic        sd_rd;
    logic [15:0] sd_dout;

    sdram_port_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .reset(reset),
        .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data),
        .dl_overflow(dl_overflow),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .gfx_req(gfx_req), .gfx_addr(gfx_addr),
        .gfx_dout(gfx_dout), .gfx_ack(gfx_ack),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt),
        .sd_we(sd_we), .sd_rd(sd_rd), .sd_dout(sd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SDRAM stand-in and the model's own view of memory
    logic [7:0] env_mem[logic [24:0]];
    logic [7:0] mdl_mem[logic [24:0]];
    int we_edges = 0;
    logic we_q = 1'b0;

    function automatic logic [7:0] dflt(input logic [24:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [15:0] word_of(input bit env, input logic [24:0] a);
        logic [24:0] lo;
        logic [24:0] hi;
        logic [7:0] bl;
        logic [7:0] bh;
        lo = {a[24:1], 1'b0};
        hi = {a[24:1], 1'b1};
        if (env) begin
            bl = env_mem.exists(lo) ? env_mem[lo] : dflt(lo);
            bh = env_mem.exists(hi) ? env_mem[hi] : dflt(hi);
        end else begin
            bl = mdl_mem.exists(lo) ? mdl_mem[lo] : dflt(lo);
            bh = mdl_mem.exists(hi) ? mdl_mem[hi] : dflt(hi);
        end
        return {bh, bl};
    endfunction

    always @(posedge clk) begin
        sd_dout <= word_of(1'b1, sd_addr);
        we_q <= sd_we;
        if (sd_we && !we_q) begin
            env_mem[sd_addr] = sd_addr[0] ? sd_din[15:8] : sd_din[7:0];
            we_edges++;
        end
    end

    // Model: one transaction at a time, timeline from its start edge
    int          cyc = 0;
    bit          m_valid = 0;
    int          free_at = 0;
    int          tx_kind = 0;
    int          tx_port = 0;
    int          tx_t = 0;
    logic [24:0] tx_addr = '0;
    logic [15:0] tx_data = '0;
    bit          tx_dl = 0;
    bit          m_pend = 0;
    logic [24:0] m_paddr = '0;
    logic [7:0]  m_pdata = '0;
    bit          m_ovf = 0;
    bit          hv[2];
    logic [23:0] htag[2];
    logic [15:0] mdout[2];

    task automatic begin_tx(input int kind, input int port,
                            input logic [24:0] a, input logic [15:0] d,
                            input int dur);
        tx_kind = kind;
        tx_port = port;
        tx_t    = cyc;
        tx_addr = a;
        tx_data = d;
        tx_dl   = 0;
        free_at = cyc + dur;
    endtask

    always @(posedge clk) begin
        bit done_w;
        bit done_r;
        bit acc;
        cyc++;
        if (reset) begin
            m_valid = 1;
            free_at = cyc + 1;
            tx_kind = 0;
            m_pend  = 0;
            m_ovf   = 0;
            hv[0] = 0; hv[1] = 0;
            mdout[0] = '0; mdout[1] = '0;
        end else begin
            done_w = (tx_kind == 3) && (cyc == tx_t + WR_WAIT + 2);
            done_r = (tx_kind == 2) && (cyc == tx_t + RD_WAIT + 2);
            acc    = dl_we && (!m_pend || done_w);
            if (done_r) begin
                mdout[tx_port] = tx_data;
                if (!(tx_dl || acc)) begin
                    hv[tx_port]   = 1;
                    htag[tx_port] = tx_addr[24:1];
                end
            end
            if (cyc >= free_at) begin
                if (m_pend) begin
                    mdl_mem[m_paddr] = m_pdata;
                    begin_tx(3, 0, m_paddr, {m_pdata, m_pdata}, WR_WAIT + 3);
                end else if (cpu_req) begin
                    if (hv[0] && htag[0] == cpu_addr[24:1])
                        begin_tx(1, 0, cpu_addr, mdout[0], 2);
                    else
                        begin_tx(2, 0, {cpu_addr[24:1], 1'b0},
                                 word_of(1'b0, cpu_addr), RD_WAIT + 3);
                end else if (gfx_req) begin
                    if (hv[1] && htag[1] == gfx_addr[24:1])
                        begin_tx(1, 1, gfx_addr, mdout[1], 2);
                    else
                        begin_tx(2, 1, {gfx_addr[24:1], 1'b0},
                                 word_of(1'b0, gfx_addr), RD_WAIT + 3);
                end
            end
            if (acc) begin
                if (tx_kind == 2) tx_dl = 1;
                m_pend  = 1;
                m_paddr = dl_addr;
                m_pdata = dl_data;
                hv[0] = 0; hv[1] = 0;
            end else if (done_w) begin
                m_pend = 0;
            end
            if (dl_we && !acc) m_ovf = 1;
        end
    end

    // Per-cycle compare against the model
    logic e_rd, e_we, e_cack, e_gack;
    always @(negedge clk) begin
        if (m_valid) begin
            e_rd = (tx_kind == 2) && cyc >= tx_t + 1 && cyc <= tx_t + RD_WAIT + 1;
            e_we = (tx_kind == 3) && cyc >= tx_t + 1 && cyc <= tx_t + WR_WAIT;
            e_cack = (tx_port == 0) &&
                     ((tx_kind == 1 && cyc == tx_t + 1) ||
                      (tx_kind == 2 && cyc == tx_t + RD_WAIT + 2));
            e_gack = (tx_port == 1) &&
                     ((tx_kind == 1 && cyc == tx_t + 1) ||
                      (tx_kind == 2 && cyc == tx_t + RD_WAIT + 2));
            chk("sd_rd", 32'(sd_rd), 32'(e_rd));
            chk("sd_we", 32'(sd_we), 32'(e_we));
            chk("rd_we_excl", 32'(sd_rd & sd_we), 32'd0);
            chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
            chk("gfx_ack", 32'(gfx_ack), 32'(e_gack));
            chk("cpu_dout", 32'(cpu_dout), 32'(mdout[0]));
            chk("gfx_dout", 32'(gfx_dout), 32'(mdout[1]));
            chk("dl_overflow", 32'(dl_overflow), 32'(m_ovf));
            chk("sd_wtbt", 32'(sd_wtbt), 32'd0);
            if (e_rd || e_we) chk("sd_addr", 32'(sd_addr), 32'(tx_addr));
            if (e_we) chk("sd_din", 32'(sd_din), 32'(tx_data));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input int port, input logic [24:0] addr,
                           input int hold, output int lat,
                           output logic [15:0] data, output logic rd1,
                           output logic [24:0] a1, output logic rd_seen);
        int  c;
        bit  got;
        c = 0; got = 0; lat = -1; data = '0;
        rd1 = 1'b0; a1 = '0; rd_seen = 1'b0;
        if (port == 0) begin cpu_addr = addr; cpu_req = 1'b1; end
        else begin gfx_addr = addr; gfx_req = 1'b1; end
        while (!got && c < 200) begin
            @(posedge clk);
            #1;
            c++;
            if (sd_rd) rd_seen = 1'b1;
            if (c == 2) begin rd1 = sd_rd; a1 = sd_addr; end
            if (hold != 0 && c >= hold) begin
                if (port == 0) cpu_req = 1'b0; else gfx_req = 1'b0;
            end
            if ((port == 0 && cpu_ack) || (port == 1 && gfx_ack)) begin
                got  = 1;
                lat  = c - 1;
                data = (port == 0) ? cpu_dout : gfx_dout;
            end
        end
        if (port == 0) cpu_req = 1'b0; else gfx_req = 1'b0;
    endtask

    task automatic dl_write(input logic [24:0] a, input logic [7:0] d);
        dl_we = 1'b1; dl_addr = a; dl_data = d;
        step(1);
        dl_we = 1'b0;
    endtask

    int          lat, lat2, cnt, e0;
    logic [15:0] d, d2, din_seen;
    logic        rd1, rds;
    logic [24:0] a1;
    logic        x1, x2;
    logic [24:0] y1, y2;

    initial begin
        reset = 1'b1; dl_we = 1'b0; dl_addr = '0; dl_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; gfx_req = 1'b0; gfx_addr = '0;
        step(3);
        reset = 1'b0;
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_ovf", 32'(dl_overflow), 32'd0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        step(2);

        do_read(0, 25'h000123, 0, lat, d, rd1, a1, rds);
        chk("miss_lat", lat, 18);
        chk("miss_rd_rise", 32'(rd1), 32'd1);
        chk("miss_sd_addr", 32'(a1), 32'h122);
        chk("miss_data", 32'(d), 32'h1F1E);

        do_read(0, 25'h000122, 0, lat, d, rd1, a1, rds);
        chk("hit_lat", lat, 1);
        chk("hit_no_rd", 32'(rds), 32'd0);
        chk("hit_data", 32'(d), 32'h1F1E);

        e0 = we_edges;
        dl_write(25'h000122, 8'h5A);
        cnt = 0; din_seen = '0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (sd_we) begin cnt++; din_seen = sd_din; end
        end
        chk("wr_width", cnt, 12);
        chk("wr_din", 32'(din_seen), 32'h5A5A);
        chk("wr_edges", we_edges - e0, 1);
        do_read(0, 25'h000122, 0, lat, d, rd1, a1, rds);
        chk("after_wr_lat", lat, 18);
        chk("after_wr_data", 32'(d), 32'h1F5A);

        fork
            do_read(0, 25'h000200, 0, lat, d, x1, y1, rds);
            do_read(1, 25'h000355, 0, lat2, d2, x2, y2, rds);
        join
        chk("both_cpu_lat", lat, 18);
        chk("both_gfx_lat", lat2, 37);
        chk("both_cpu_data", 32'(d), 32'h3D3C);
        chk("both_gfx_data", 32'(d2), 32'h6968);

        fork
            do_read(0, 25'h000201, 0, lat, d, x1, y1, rds);
            do_read(1, 25'h000480, 0, lat2, d2, x2, y2, rds);
        join
        chk("hitmiss_cpu_lat", lat, 1);
        chk("hitmiss_gfx_lat", lat2, 20);
        chk("hitmiss_gfx_data", 32'(d2), 32'hBDBC);

        step(2);
        e0 = we_edges;
        dl_we = 1'b1; dl_addr = 25'h40; dl_data = 8'h11;
        step(1);
        dl_addr = 25'h41; dl_data = 8'h22;
        step(1);
        dl_we = 1'b0;
        step(20);
        chk("ovf_set", 32'(dl_overflow), 32'd1);
        chk("ovf_one_write", we_edges - e0, 1);
        do_read(0, 25'h000041, 0, lat, d, rd1, a1, rds);
        chk("ovf_read_lat", lat, 18);
        chk("ovf_read_data", 32'(d), 32'h7D11);

        fork
            do_read(1, 25'h000600, 0, lat, d, x1, y1, rds);
            begin
                step(5);
                dl_write(25'h000700, 8'h99);
            end
        join
        chk("dlmid_lat", lat, 18);
        chk("dlmid_data", 32'(d), 32'h3D3C);
        step(20);
        do_read(1, 25'h000600, 0, lat, d, x1, y1, rds);
        chk("dlmid_remiss", lat, 18);
        do_read(1, 25'h000600, 0, lat, d, x1, y1, rds);
        chk("dlmid_rehit", lat, 1);

        do_read(0, 25'h000800, 1, lat, d, rd1, a1, rds);
        chk("withdraw_lat", lat, 18);
        chk("withdraw_data", 32'(d), 32'h3D3C);
        do_read(0, 25'h000801, 0, lat, d, rd1, a1, rds);
        chk("withdraw_hit", lat, 1);

        step(2);
        cpu_addr = 25'h000900; cpu_req = 1'b1;
        step(6);
        chk("rst_mid_rd_high", 32'(sd_rd), 32'd1);
        reset = 1'b1;
        step(1);
        chk("rst_mid_rd_low", 32'(sd_rd), 32'd0);
        cpu_req = 1'b0;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1);
            if (cpu_ack || gfx_ack) cnt++;
        end
        chk("rst_mid_no_ack", cnt, 0);
        do_read(1, 25'h000600, 0, lat, d, x1, y1, rds);
        chk("rst_hit_cleared", lat, 18);

        step(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Sits directly upstream of the single-port SDRAM controller.
- Multiplexes three clients onto the controller's edge-triggered rd/we interface:
  - ROM download write port (8-bit, from the loader);
  - CPU ROM read port (16-bit);
  - graphics ROM read port (16-bit).
- Each read port has a one-word hit register, so a repeated fetch of the same word completes without an SDRAM access.
- Fixed priority: download > CPU > graphics.

Parameters:
- RD_WAIT, 16: cycles sd_rd is held before sd_dout is sampled. Must be at least the controller's worst-case read latency, including one refresh.
- WR_WAIT, 12: cycles sd_we is held before a write is considered complete.

Ports:
- clk  in  1  system clock (same clock as the SDRAM controller)
- reset  in  1  synchronous, active-high
- dl_we  in  1  one-cycle download write strobe
- dl_addr  in  25  download byte address
- dl_data  in  8  download byte
- dl_overflow  out  1  sticky: dl_we arrived while a download write was still pending
- cpu_req  in  1  level request; held with cpu_addr stable until cpu_ack
- cpu_addr  in  25  byte address; bit 0 is ignored
- cpu_dout  out  16  read word, valid from cpu_ack onward
- cpu_ack  out  1  one-cycle completion pulse
- gfx_req, gfx_addr, gfx_dout, gfx_ack  same as the cpu_* set
- sd_addr  out  25  to controller addr
- sd_din  out  16  to controller din
- sd_wtbt  out  2  to controller wtbt; always 2'b00 (8-bit mode)
- sd_we  out  1  to controller we
- sd_rd  out  1  to controller rd
- sd_dout  in  16  from controller dout

Behaviour:
- Reset values: every output is 0. State is IDLE. The pending download and both hit registers are invalid. dl_overflow is cleared.
- All outputs are registered.
- Download capture: dl_we loads the pending register {addr, data} and sets the pending flag. If pending is already set, the write is dropped and dl_overflow is set. If dl_we coincides with completion of the pending write (WDONE), it is accepted.
- Any accepted dl_we invalidates both hit registers.
- IDLE, arbitration in priority order:
  1. pending download -> WISSUE.
  2. cpu_req, with hit valid and cpu_addr[24:1] equal to the hit tag -> HIT_CPU.
  3. cpu_req, miss -> RISSUE(cpu).
  4. gfx_req hit -> HIT_GFX.
  5. gfx_req miss -> RISSUE(gfx).
- A CPU hit is served before a graphics miss.
- HIT_x: pulse x_ack for one cycle; x_dout already holds the word. Next state IDLE. Latency: ack one cycle after req is sampled.
- RISSUE: sd_addr = {addr[24:1], 1'b0}; sd_rd <= 1; load counter with RD_WAIT-1; next state RWAIT.
- RWAIT: decrement the counter; at 0 -> RDONE.
- RDONE:
  - x_dout <= sd_dout; x_ack pulse.
  - Hit tag <= addr[24:1]; hit valid <= 1, unless a dl_we was accepted during the transaction.
  - sd_rd <= 0; next state IDLE.
- Read miss latency: ack at cycle RD_WAIT+2 after the IDLE sample.
- WISSUE: sd_addr = pending addr (byte); sd_din = {data, data}; sd_we <= 1; load counter with WR_WAIT-1; next state WWAIT -> WDONE.
- WDONE: sd_we <= 0; clear pending; next state IDLE.
- Edge spacing: sd_rd and sd_we are both low for at least one cycle (IDLE) between transactions, so the controller always sees a fresh rising edge. sd_rd and sd_we are never high together.
- Address latching: the client address is latched at RISSUE. A client changing its address mid-transaction violates the protocol; the ack still returns the originally latched word.
- Request withdrawal: a request dropped before ack is still completed internally. The ack is still pulsed and the hit register is updated.
- Starvation: continuous cpu_req misses starve gfx. This is accepted; the CPU duty cycle guarantees gaps.
- Reset mid-transaction: sd_rd and sd_we drop in the next cycle; no ack is issued.

Test Plan:
- Reset, then cpu_req with cpu_addr=0x000123 -> sd_rd rises 1 cycle later with sd_addr=0x000122; with RD_WAIT=16, cpu_ack pulses 18 cycles after the sample and cpu_dout equals the model word at 0x122.
- Repeat cpu_req at 0x000122 -> cpu_ack 1 cycle later; sd_rd stays 0; data unchanged.
- dl_we addr=0x000122 data=0x5A -> sd_we held 12 cycles, sd_din=0x5A5A, sd_wtbt=00; the following cpu_req at 0x122 misses and issues sd_rd.
- cpu_req and gfx_req raised in the same cycle, both misses -> CPU served first; sd_rd drops for at least 1 cycle; gfx served next; each ack exactly one pulse.
- Two dl_we 1 cycle apart -> second dropped, dl_overflow=1, exactly one sd_we transaction.
- reset asserted during RWAIT -> sd_rd=0 next cycle, no ack, hit registers invalid.
